multi_op_sched: RTL and testbench



---
 rtl/multi_op_sched_if.sv | 43 ++++
 rtl/multi_op_sched.sv | 188 ++++++++++++++++++
 tb/tb_multi_op_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_op_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_op_sched_if
// Description : Command and result bundle between two command producers,
//               the multi_op_sched scheduler and the result consumer.
//               req_*  : two requesters' commands plus valid/ready per requester
//               out_*  : tagged result with valid/ready
//               master : producer/consumer side, slave : scheduler side
// Revision    : 1.0  initial release
// ============================================================================
interface multi_op_sched_if #(
    parameter int N = 64,
    parameter int M = 64
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [N-1:0]     req0_a;
    logic [N-1:0]     req1_a;
    logic [M-1:0]     req0_b;
    logic [M-1:0]     req1_b;
    logic [N+M+1:0]   req0_c;
    logic [N+M+1:0]   req1_c;
    logic [1:0]       req0_op;
    logic [1:0]       req1_op;
    logic             out_valid;
    logic             out_ready;
    logic [N+M+1:0]   out_y;
    logic             out_id;
    logic [1:0]       out_op;

    modport master (
        output req_valid, req0_a, req1_a, req0_b, req1_b,
               req0_c, req1_c, req0_op, req1_op, out_ready,
        input  req_ready, out_valid, out_y, out_id, out_op
    );

    modport slave (
        input  req_valid, req0_a, req1_a, req0_b, req1_b,
               req0_c, req1_c, req0_op, req1_op, out_ready,
        output req_ready, out_valid, out_y, out_id, out_op
    );
endinterface
`default_nettype wire

// File: rtl/multi_op_sched.sv
`default_nettype none
// ============================================================================
// Module      : multi_op (datapath) / multi_op_sched (scheduler, top)
// Description : multi_op computes A+B, A-B, A*B or C+A*B at full N+M+2 signed
//               precision (wrapping modulo 2^(N+M+2)).
//               multi_op_sched round-robin arbitrates two requesters onto one
//               multi_op, registers the operands, captures the result and
//               presents it tagged with requester ID and opcode.
//   Ports (multi_op_sched):
//     clk      : rising-edge clock
//     rst_n    : asynchronous active-low reset
//     bus      : multi_op_sched_if.slave (commands in, tagged result out)
//     busy     : high whenever the scheduler is not idle
//     ops_done : results handed off, wraps modulo 2^CNT_W
// Revision    : 1.0  initial release
// ============================================================================
module multi_op #(
    parameter int N = 64,
    parameter int M = 64
) (
    input  wire logic [N-1:0]   a,
    input  wire logic [M-1:0]   b,
    input  wire logic [N+M+1:0] c,
    input  wire logic           s1,
    input  wire logic           s0,
    output logic      [N+M+1:0] y
);
    localparam int W = N + M + 2;

    logic [W-1:0] a_x;
    logic [W-1:0] b_x;
    logic [W-1:0] prod;

    // Sign-extend to the result width; the low W bits of the product are exact
    // because a signed N x M product needs only N+M bits.
    assign a_x  = {{(W-N){a[N-1]}}, a};
    assign b_x  = {{(W-M){b[M-1]}}, b};
    assign prod = a_x * b_x;

    always_comb begin
        y = '0;
        case ({s1, s0})
            2'b00:   y = a_x + b_x;
            2'b01:   y = a_x - b_x;
            2'b10:   y = prod;
            default: y = c + prod;
        endcase
    end
endmodule

module multi_op_sched #(
    parameter int N     = 64,
    parameter int M     = 64,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    multi_op_sched_if.slave       bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      ops_done
);
    localparam int W = N + M + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic            last_id;
    logic [N-1:0]    a_q;
    logic [M-1:0]    b_q;
    logic [W-1:0]    c_q;
    logic [1:0]      op_q;
    logic            id_q;
    logic            out_valid_q;
    logic [W-1:0]    out_y_q;
    logic            out_id_q;
    logic [1:0]      out_op_q;

    logic            grant_valid;
    logic            grant_id;
    logic            handshake;
    logic [W-1:0]    dp_y;

    // Grant only exists in IDLE; on contention the requester that did not win
    // last time goes first.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_id    = ~last_id;
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_id    = 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = {grant_valid & grant_id, grant_valid & ~grant_id};
    assign handshake     = |(bus.req_valid & bus.req_ready);

    // The datapath sees only registered operands, never the request ports.
    multi_op #(
        .N (N),
        .M (M)
    ) u_multi_op (
        .a  (a_q),
        .b  (b_q),
        .c  (c_q),
        .s1 (op_q[1]),
        .s0 (op_q[0]),
        .y  (dp_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            last_id     <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            op_q        <= 2'b00;
            id_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_id_q    <= 1'b0;
            out_op_q    <= 2'b00;
            ops_done    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        a_q     <= grant_id ? bus.req1_a  : bus.req0_a;
                        b_q     <= grant_id ? bus.req1_b  : bus.req0_b;
                        c_q     <= grant_id ? bus.req1_c  : bus.req0_c;
                        op_q    <= grant_id ? bus.req1_op : bus.req0_op;
                        id_q    <= grant_id;
                        last_id <= grant_id;
                        state   <= EXEC;
                        busy    <= 1'b1;
                    end
                end
                EXEC: begin
                    out_y_q     <= dp_y;
                    out_id_q    <= id_q;
                    out_op_q    <= op_q;
                    out_valid_q <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        ops_done    <= ops_done + CNT_W'(1);
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_op    = out_op_q;
endmodule
`default_nettype wire

// File: tb/tb_multi_op_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_op_sched
// Description : Self-checking bench for multi_op_sched (N=M=8, CNT_W=4).
//               Directed cases with literal results, then randomized traffic
//               checked every cycle against a transaction-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multi_op_sched;
    localparam int N     = 8;
    localparam int M     = 8;
    localparam int W     = N + M + 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             busy;
    logic [CNT_W-1:0] ops_done;

    multi_op_sched_if #(.N(N), .M(M)) bus ();

    multi_op_sched #(
        .N     (N),
        .M     (M),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .ops_done (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a command becomes visible one cycle after acceptance
    // and stays visible until taken.
    int          m_stage;     // 0 free, 1 command accepted, 2 result on offer
    bit          m_valid;
    logic [W-1:0] m_y;
    bit          m_id;
    logic [1:0]  m_op;
    int          m_ops;
    bit          m_last;
    logic [W-1:0] p_y;
    bit          p_id;
    logic [1:0]  p_op;
    logic [1:0]  last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_y(input logic [1:0] op, input logic [N-1:0] a,
                                           input logic [M-1:0] b, input logic [W-1:0] c);
        longint sa;
        longint sb;
        longint sc;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        case (op)
            2'b00:   r = sa + sb;
            2'b01:   r = sa - sb;
            2'b10:   r = sa * sb;
            default: r = sc + sa * sb;
        endcase
        return r[W-1:0];
    endfunction

    task automatic model_reset();
        m_stage = 0;
        m_valid = 0;
        m_y     = '0;
        m_id    = 0;
        m_op    = 2'b00;
        m_ops   = 0;
        m_last  = 1;
    endtask

    // Called just after a falling edge: drive inputs, check the grant, advance
    // the model over the next rising edge, then check outputs at the following
    // falling edge.
    task automatic step(input logic [1:0] v, input logic ordy,
                        input logic [1:0] op0, input logic [1:0] op1,
                        input logic [N-1:0] a0, input logic [N-1:0] a1,
                        input logic [M-1:0] b0, input logic [M-1:0] b1,
                        input logic [W-1:0] c0, input logic [W-1:0] c1);
        logic [1:0] exp_rdy;
        bus.req_valid = v;
        bus.out_ready = ordy;
        bus.req0_op = op0;  bus.req1_op = op1;
        bus.req0_a  = a0;   bus.req1_a  = a1;
        bus.req0_b  = b0;   bus.req1_b  = b1;
        bus.req0_c  = c0;   bus.req1_c  = c1;
        #1;
        exp_rdy = 2'b00;
        if (m_stage == 0) begin
            if (v == 2'b01)      exp_rdy = 2'b01;
            else if (v == 2'b10) exp_rdy = 2'b10;
            else if (v == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
        end
        chk("req_ready", bus.req_ready, exp_rdy);
        last_ready = bus.req_ready;
        if (m_stage == 2) begin
            if (ordy) begin
                m_stage = 0;
                m_valid = 0;
                m_ops   = (m_ops + 1) % (1 << CNT_W);
            end
        end else if (m_stage == 1) begin
            m_stage = 2;
            m_valid = 1;
            m_y     = p_y;
            m_id    = p_id;
            m_op    = p_op;
        end else if (exp_rdy != 2'b00) begin
            m_stage = 1;
            p_id    = exp_rdy[1];
            p_op    = p_id ? op1 : op0;
            p_y     = p_id ? ref_y(op1, a1, b1, c1) : ref_y(op0, a0, b0, c0);
            m_last  = p_id;
        end
        @(negedge clk);
        chk("out_valid", bus.out_valid, m_valid);
        chk("busy", busy, (m_stage != 0));
        chk("ops_done", ops_done, m_ops);
        if (m_valid) begin
            chk("out_y", bus.out_y, m_y);
            chk("out_id", bus.out_id, m_id);
            chk("out_op", bus.out_op, m_op);
        end
    endtask

    task automatic idle_step(input logic ordy);
        step(2'b00, ordy, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic rand_step(input logic [1:0] v, input logic ordy);
        step(v, ordy, 2'($urandom), 2'($urandom), N'($urandom), N'($urandom),
             M'($urandom), M'($urandom), W'($urandom), W'($urandom));
    endtask

    // One command through an otherwise quiet scheduler with a literal result.
    task automatic run_cmd(input bit id, input logic [1:0] op, input logic [N-1:0] a,
                           input logic [M-1:0] b, input logic [W-1:0] c,
                           input logic [W-1:0] exp_y);
        logic [1:0] v;
        v = id ? 2'b10 : 2'b01;
        step(v, 1'b0, op, op, a, a, b, b, c, c);
        chk("hs_ready", last_ready, v);
        chk("lat_early", bus.out_valid, 1'b0);
        idle_step(1'b0);
        chk("lat_valid", bus.out_valid, 1'b1);
        chk("lit_y", bus.out_y, exp_y);
        chk("lit_id", bus.out_id, id);
        chk("lit_op", bus.out_op, op);
        idle_step(1'b1);
        chk("valid_drop", bus.out_valid, 1'b0);
    endtask

    initial begin
        int          hs_idx [4];
        bit          hs_id  [4];
        int          n_hs;
        logic [W-1:0] y0;

        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b0;
        bus.req0_op = 2'b00; bus.req1_op = 2'b00;
        bus.req0_a  = '0;    bus.req1_a  = '0;
        bus.req0_b  = '0;    bus.req1_b  = '0;
        bus.req0_c  = '0;    bus.req1_c  = '0;
        last_ready  = 2'b00;
        p_y = '0; p_id = 0; p_op = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_out_y", bus.out_y, 0);
        chk("rst_out_id", bus.out_id, 1'b0);
        chk("rst_out_op", bus.out_op, 2'b00);

        // Directed arithmetic.
        run_cmd(1'b0, 2'b00, 8'd5, 8'd3, '0, 18'd8);
        chk("ops_after_first", ops_done, 1);
        run_cmd(1'b0, 2'b10, 8'hFC, 8'd3, '0, 18'h3FFF4);
        run_cmd(1'b0, 2'b11, 8'd7, 8'hFE, 18'd100, 18'd86);
        run_cmd(1'b1, 2'b01, 8'd3, 8'd5, '0, 18'h3FFFE);

        // Continuous contention: last winner was requester 1.
        n_hs = 0;
        for (int i = 0; i < 12; i++) begin
            rand_step(2'b11, 1'b1);
            if (last_ready != 2'b00 && n_hs < 4) begin
                hs_idx[n_hs] = i;
                hs_id[n_hs]  = last_ready[1];
                n_hs++;
            end
        end
        chk("cont_count", n_hs, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_hs) begin
                chk("cont_order", hs_id[i], i % 2);
                if (i > 0) chk("cont_spacing", hs_idx[i] - hs_idx[i-1], 3);
            end
        end
        repeat (3) idle_step(1'b1);

        // Back-pressure in HOLD.
        step(2'b01, 1'b0, 2'b10, 2'b00, 8'd3, '0, 8'd4, '0, '0, '0);
        idle_step(1'b0);
        y0 = bus.out_y;
        chk("hold_y_lit", y0, 18'd12);
        for (int i = 0; i < 5; i++) begin
            rand_step(2'b11, 1'b0);
            chk("hold_y_stable", bus.out_y, y0);
            chk("hold_id_stable", bus.out_id, 1'b0);
            chk("hold_op_stable", bus.out_op, 2'b10);
            chk("hold_ready", last_ready, 2'b00);
            chk("hold_busy", busy, 1'b1);
        end
        idle_step(1'b1);
        chk("hold_drop", bus.out_valid, 1'b0);

        // Asynchronous reset while a command is in EXEC.
        step(2'b01, 1'b1, 2'b11, 2'b00, 8'd9, '0, 8'd9, '0, 18'd1, '0);
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ops_done", ops_done, 0);
        chk("arst_out_y", bus.out_y, 0);
        chk("arst_out_id", bus.out_id, 1'b0);
        chk("arst_out_op", bus.out_op, 2'b00);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("arst_no_pulse", bus.out_valid, 1'b0);
        end
        rst_n = 1'b1;
        rand_step(2'b11, 1'b1);
        chk("arst_first_grant", last_ready, 2'b01);
        idle_step(1'b1);
        idle_step(1'b1);

        // Counter wrap: 1 op done so far, 15 more wraps a 4-bit count to 0.
        for (int i = 0; i < 15; i++) begin
            logic [1:0]   op;
            logic [N-1:0] a;
            logic [M-1:0] b;
            logic [W-1:0] c;
            op = 2'($urandom);
            a  = N'($urandom);
            b  = M'($urandom);
            c  = W'($urandom);
            run_cmd(1'($urandom), op, a, b, c, ref_y(op, a, b, c));
        end
        chk("ops_wrap", ops_done, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rand_step(2'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
